// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: PC / pipeline-register enables, bubbles and
// flushes for load-use, branch redirect, multi-cycle MDU occupancy and data-memory waits.
module hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_ex_memrd,
  input  logic [4:0]       id_ex_rd,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic             if_id_uses_rs2,
  input  logic             ex_branch_taken,
  input  logic             ex_mdu_start,
  input  logic             mdu_done,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_bubble,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic [1:0]       state
);

  localparam int unsigned FC_W = 3;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MDU   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [FC_W-1:0]  fcnt_q, fcnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] fev_q, fev_d;

  logic mem_freeze;
  logic load_use;
  logic redirect;

  assign mem_freeze = dmem_req & ~dmem_ack;

  // Load in EX feeding a source operand of the instruction in ID; x0 never hazards.
  assign load_use = id_ex_memrd && (id_ex_rd != 5'd0) &&
                    ((id_ex_rd == if_id_rs1) || (if_id_uses_rs2 && (id_ex_rd == if_id_rs2)));

  assign redirect = rst && !mem_freeze && (state_q == ST_RUN) && ex_branch_taken;

  // State register and counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_RUN;
      fcnt_q  <= '0;
      stall_q <= '0;
      fev_q   <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      stall_q <= stall_d;
      fev_q   <= fev_d;
    end
  end

  // Next-state logic; a memory freeze holds the whole sequence
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (!mem_freeze) begin
      unique case (state_q)
        ST_RUN: begin
          if (ex_branch_taken) begin
            if (FLUSH_CYCLES != 0) begin
              state_d = ST_FLUSH;
              fcnt_d  = FC_W'(FLUSH_CYCLES);
            end
          end else if (ex_mdu_start) begin
            state_d = ST_MDU;
          end
        end
        ST_MDU: begin
          if (mdu_done) state_d = ST_RUN;
        end
        ST_FLUSH: begin
          fcnt_d = fcnt_q - FC_W'(1);
          if (fcnt_q == FC_W'(1)) state_d = ST_RUN;
        end
        default: begin
          state_d = ST_RUN;
          fcnt_d  = '0;
        end
      endcase
    end
  end

  // Output logic from registered state and current inputs
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    ex_mem_write  = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    if (!rst) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (mem_freeze) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (ex_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (ex_mdu_start) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_bubble = 1'b1;
          end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end
        end
        ST_MDU: begin
          if (!mdu_done) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_bubble = 1'b1;
          end
        end
        ST_FLUSH: begin
          if_id_flush = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Saturating performance counters
  always_comb begin
    stall_d = stall_q;
    fev_d   = fev_q;
    if (!pc_write && (stall_q != {CNT_W{1'b1}})) stall_d = stall_q + CNT_W'(1);
    if (redirect && (fev_q != {CNT_W{1'b1}}))    fev_d   = fev_q + CNT_W'(1);
  end

  assign stall_cycles = stall_q;
  assign flush_events = fev_q;
  assign state        = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios with literal expectations plus randomized
// traffic, all checked every cycle against a behavioural pipeline-hazard model.
module tb_hazard_ctrl;

  localparam int unsigned FC    = 2;
  localparam int unsigned CW    = 4;
  localparam int          SAT   = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_ex_memrd;
  logic [4:0]    id_ex_rd, if_id_rs1, if_id_rs2;
  logic          if_id_uses_rs2, ex_branch_taken, ex_mdu_start, mdu_done;
  logic          dmem_req, dmem_ack;
  logic          pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic          if_id_flush, id_ex_bubble, ex_mem_bubble;
  logic [CW-1:0] stall_cycles, flush_events;
  logic [1:0]    state;

  int n_vec  = 0;
  int n_miss = 0;

  // Model: is the MDU occupying EX, how many flush cycles remain, and the two counters.
  bit m_mdu;
  int m_flush_left;
  int m_stall, m_fev;

  hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_ex_memrd(id_ex_memrd), .id_ex_rd(id_ex_rd),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .if_id_uses_rs2(if_id_uses_rs2),
    .ex_branch_taken(ex_branch_taken), .ex_mdu_start(ex_mdu_start), .mdu_done(mdu_done),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
    .ex_mem_write(ex_mem_write), .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .ex_mem_bubble(ex_mem_bubble), .stall_cycles(stall_cycles), .flush_events(flush_events),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    id_ex_memrd = 0; id_ex_rd = 0; if_id_rs1 = 0; if_id_rs2 = 0; if_id_uses_rs2 = 0;
    ex_branch_taken = 0; ex_mdu_start = 0; mdu_done = 0; dmem_req = 0; dmem_ack = 0;
  endtask

  // Settle the inputs driven at the falling edge, compare against the model, advance the model.
  task automatic settle_check();
    bit freeze, lu, stall_pipe;
    int e_pc, e_ifw, e_idw, e_exw, e_iff, e_idb, e_exb, e_state;
    #1;
    freeze = dmem_req && !dmem_ack;
    lu = id_ex_memrd && id_ex_rd != 0 &&
         (id_ex_rd == if_id_rs1 || (if_id_uses_rs2 && id_ex_rd == if_id_rs2));
    e_pc = 1; e_ifw = 1; e_idw = 1; e_exw = 1; e_iff = 0; e_idb = 0; e_exb = 0;
    stall_pipe = 0;
    if (!rst) begin
      e_pc = 0; e_ifw = 0; e_idw = 0; e_exw = 0; e_iff = 1; e_idb = 1;
    end else if (freeze) begin
      e_pc = 0; e_ifw = 0; e_idw = 0; e_exw = 0;
    end else if (m_mdu) begin
      stall_pipe = !mdu_done;
    end else if (m_flush_left > 0) begin
      e_iff = 1;
    end else if (ex_branch_taken) begin
      e_iff = 1; e_idb = 1;
    end else if (ex_mdu_start) begin
      stall_pipe = 1;
    end else if (lu) begin
      e_pc = 0; e_ifw = 0; e_idb = 1;
    end
    if (stall_pipe) begin
      e_pc = 0; e_ifw = 0; e_idw = 0; e_exb = 1;
    end
    e_state = m_mdu ? 1 : (m_flush_left > 0 ? 2 : 0);

    chk("pc_write",      int'(pc_write),      e_pc);
    chk("if_id_write",   int'(if_id_write),   e_ifw);
    chk("id_ex_write",   int'(id_ex_write),   e_idw);
    chk("ex_mem_write",  int'(ex_mem_write),  e_exw);
    chk("if_id_flush",   int'(if_id_flush),   e_iff);
    chk("id_ex_bubble",  int'(id_ex_bubble),  e_idb);
    chk("ex_mem_bubble", int'(ex_mem_bubble), e_exb);
    chk("state",         int'(state),         e_state);
    chk("stall_cycles",  int'(stall_cycles),  m_stall);
    chk("flush_events",  int'(flush_events),  m_fev);

    if (!rst) begin
      m_mdu = 0; m_flush_left = 0; m_stall = 0; m_fev = 0;
    end else begin
      if (e_pc == 0 && m_stall < SAT) m_stall++;
      if (!freeze) begin
        if (m_mdu) begin
          if (mdu_done) m_mdu = 0;
        end else if (m_flush_left > 0) begin
          m_flush_left--;
        end else if (ex_branch_taken) begin
          if (m_fev < SAT) m_fev++;
          m_flush_left = FC;
        end else if (ex_mdu_start) begin
          m_mdu = 1;
        end
      end
    end
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_inputs(); rst = 0;
    settle_check(); next();
    rst = 1;
  endtask

  initial begin
    idle_inputs();
    rst = 0;
    m_mdu = 0; m_flush_left = 0; m_stall = 0; m_fev = 0;
    @(posedge clk);
    @(negedge clk);

    // Reset held three cycles, then release
    for (int i = 0; i < 3; i++) begin
      settle_check();
      chk("rst_pc_write", int'(pc_write), 0);
      chk("rst_if_id_flush", int'(if_id_flush), 1);
      chk("rst_state", int'(state), 0);
      chk("rst_stall_cycles", int'(stall_cycles), 0);
      next();
    end
    rst = 1;
    settle_check();
    chk("release_writes", int'({pc_write, if_id_write, id_ex_write, ex_mem_write}), 15);
    next();

    // Load-use on rs2, then the non-hazard variants
    id_ex_memrd = 1; id_ex_rd = 5; if_id_rs1 = 3; if_id_rs2 = 5; if_id_uses_rs2 = 1;
    settle_check();
    chk("lu_pc_write", int'(pc_write), 0);
    chk("lu_id_ex_bubble", int'(id_ex_bubble), 1);
    next();
    idle_inputs();
    settle_check();
    chk("lu_release", int'(pc_write), 1);
    chk("lu_stall_cycles", int'(stall_cycles), 1);
    next();
    id_ex_memrd = 1; id_ex_rd = 0; if_id_rs1 = 0; if_id_rs2 = 0; if_id_uses_rs2 = 1;
    settle_check();
    chk("lu_x0_no_stall", int'(pc_write), 1);
    next();
    id_ex_rd = 5; if_id_rs1 = 3; if_id_rs2 = 5; if_id_uses_rs2 = 0;
    settle_check();
    chk("lu_imm_no_stall", int'(pc_write), 1);
    next();
    idle_inputs();

    // Taken branch: three flush cycles, bubble on the first only
    do_reset();
    ex_branch_taken = 1;
    settle_check();
    chk("br0_flush", int'(if_id_flush), 1);
    chk("br0_bubble", int'(id_ex_bubble), 1);
    next();
    ex_branch_taken = 0;
    for (int i = 1; i < 3; i++) begin
      settle_check();
      chk("brN_flush", int'(if_id_flush), 1);
      chk("brN_bubble", int'(id_ex_bubble), 0);
      chk("brN_state", int'(state), 2);
      next();
    end
    settle_check();
    chk("br_end_flush", int'(if_id_flush), 0);
    chk("br_end_state", int'(state), 0);
    chk("br_flush_events", int'(flush_events), 1);
    next();

    // MDU: done four cycles after start
    do_reset();
    ex_mdu_start = 1;
    for (int i = 0; i < 4; i++) begin
      settle_check();
      chk("mdu_pc_write", int'(pc_write), 0);
      chk("mdu_ex_mem_bubble", int'(ex_mem_bubble), 1);
      next();
      ex_mdu_start = 0;
    end
    mdu_done = 1;
    settle_check();
    chk("mdu_done_pc_write", int'(pc_write), 1);
    chk("mdu_done_bubble", int'(ex_mem_bubble), 0);
    next();
    mdu_done = 0;
    settle_check();
    chk("mdu_stall_cycles", int'(stall_cycles), 4);
    chk("mdu_back_run", int'(state), 0);
    next();

    // Memory wait inside MDU_BUSY masks mdu_done
    do_reset();
    ex_mdu_start = 1;
    settle_check(); next();
    ex_mdu_start = 0; mdu_done = 1; dmem_req = 1; dmem_ack = 0;
    for (int i = 0; i < 3; i++) begin
      settle_check();
      chk("mw_writes", int'({pc_write, if_id_write, id_ex_write, ex_mem_write}), 0);
      chk("mw_state", int'(state), 1);
      next();
    end
    dmem_ack = 1;
    settle_check();
    chk("mw_done_pc_write", int'(pc_write), 1);
    next();
    idle_inputs();
    settle_check();
    chk("mw_state_run", int'(state), 0);
    next();

    // Saturation: 20+ consecutive stall cycles
    do_reset();
    ex_mdu_start = 1;
    settle_check(); next();
    ex_mdu_start = 0;
    for (int i = 0; i < 20; i++) begin
      settle_check(); next();
    end
    settle_check();
    chk("sat_stall_cycles", int'(stall_cycles), 15);
    next();
    mdu_done = 1;
    settle_check();
    chk("sat_hold", int'(stall_cycles), 15);
    next();
    idle_inputs();

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      rst             = ($urandom_range(0, 49) != 0);
      id_ex_memrd     = 1'($urandom_range(0, 1));
      id_ex_rd        = 5'($urandom_range(0, 3));
      if_id_rs1       = 5'($urandom_range(0, 3));
      if_id_rs2       = 5'($urandom_range(0, 3));
      if_id_uses_rs2  = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      ex_mdu_start    = ($urandom_range(0, 9) == 0);
      mdu_done        = ($urandom_range(0, 3) == 0);
      dmem_req        = ($urandom_range(0, 2) == 0);
      dmem_ack        = 1'($urandom_range(0, 1));
      settle_check();
      next();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
